// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: issue/operand inputs and status/result outputs of the multiply sequencer
interface mul_sequencer_if #(parameter int WIDTH = 32);
  logic             valid;
  logic [4:0]       alu_ctl;
  logic             sign;
  logic             flush;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  modport master (output valid, alu_ctl, sign, flush, op_a, op_b,
                  input busy, stall, done, result_hi, result_lo);
  modport slave (input valid, alu_ctl, sign, flush, op_a, op_b,
                 output busy, stall, done, result_hi, result_lo);
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier that stalls EX and pulses done with a 2*WIDTH product
module mul_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [4:0] MUL_CODE = 5'b11010
) (
  input logic           clk,
  input logic           reset,
  mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplr_q, mplr_d;
  logic               neg_q, neg_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               start;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, fin;
  // next-state: latch magnitudes on start, one add/shift step per RUN cycle, sign-fix and register in FIN
  always_comb begin
    start   = bus.valid & (bus.alu_ctl == MUL_CODE) & (state_q == IDLE) & ~bus.flush;
    sum     = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    prod    = {acc_q[WIDTH-1:0], mplr_q};
    fin     = neg_q ? -prod : prod;
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      acc_d   = '0;
      mcand_d = bus.sign & bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
      mplr_d  = bus.sign & bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
      neg_d   = bus.sign & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
    end else if (state_q == RUN) begin
      state_d = bus.flush ? IDLE : (cnt_q == CW'(WIDTH - 1) ? FIN : RUN);
      cnt_d   = bus.flush ? cnt_q : cnt_q + 1'b1;
      acc_d   = bus.flush ? acc_q : {1'b0, sum[WIDTH:1]};
      mplr_d  = bus.flush ? mplr_q : {sum[0], mplr_q[WIDTH-1:1]};
    end else if (state_q == FIN) begin
      state_d = IDLE;
      hi_d    = bus.flush ? hi_q : fin[2*WIDTH-1:WIDTH];
      lo_d    = bus.flush ? lo_q : fin[WIDTH-1:0];
      done_d  = ~bus.flush;
    end
  end
  // state and result registers, reset has priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.stall     = (state_q == RUN) | start;
  assign bus.done      = done_q;
  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and random multiplies checked against an arithmetic reference product
module tb_mul_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] last;
  mul_sequencer_if #(.WIDTH(32)) bus();
  mul_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return s ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.valid = 1'b1;
    bus.alu_ctl = 5'b11010;
    bus.op_a = a;
    bus.op_b = b;
    bus.sign = s;
    #1 chk("start_stall", 64'(bus.stall), 64'd1);
    @(posedge clk);
  endtask

  task automatic wait_done(input logic [63:0] exp, input string tag, input logic hold);
    int edges = 1;
    int stalls = 0;
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else begin
        stalls += int'(bus.stall);
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        bus.sign = 1'($urandom);
        if (!hold) bus.valid = 1'b0;
        @(posedge clk);
        edges++;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(edges), 64'd34);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'd32);
    chk({tag, "_product"}, {bus.result_hi, bus.result_lo}, exp);
    last = exp;
  endtask

  task automatic single_pulse(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic s;
    int dones;
    bus.valid = 0; bus.alu_ctl = 0; bus.sign = 0; bus.flush = 0; bus.op_a = 0; bus.op_b = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    reset = 1'b0;
    issue(32'd3, 32'd5, 1'b0);
    wait_done(64'h0000_0000_0000_000F, "u3x5", 0);
    single_pulse("u3x5");
    issue(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(64'hFFFF_FFFF_FFFF_FFF1, "sm3x5", 0);
    single_pulse("sm3x5");
    issue(32'hFFFF_FFFD, 32'd5, 1'b0);
    wait_done(64'h0000_0004_FFFF_FFF1, "um3x5", 0);
    single_pulse("um3x5");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(64'hFFFF_FFFE_0000_0001, "umax", 0);
    single_pulse("umax");
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(64'h4000_0000_0000_0000, "smin", 0);
    single_pulse("smin");
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    bus.valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_stall", 64'(bus.stall), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    chk("flush_no_done", 64'(dones), 64'd0);
    chk("flush_result_kept", {bus.result_hi, bus.result_lo}, last);
    bus.valid = 1'b1; bus.alu_ctl = 5'b11010; bus.flush = 1'b1;
    #1 chk("flush_idle_stall", 64'(bus.stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flush_idle_busy", 64'(bus.busy), 64'd0);
    bus.flush = 1'b0; bus.valid = 1'b0;
    issue(32'd7, 32'd6, 1'b0);
    wait_done(64'h2A, "u7x6", 0);
    single_pulse("u7x6");
    a = $urandom; b = $urandom;
    issue(a, b, 1'b1);
    wait_done(ref_mul(a, b, 1'b1), "hold", 1);
    bus.op_a = 32'd9; bus.op_b = 32'd11; bus.sign = 1'b0;
    #1 chk("b2b_start_stall", 64'(bus.stall), 64'd1);
    @(posedge clk);
    wait_done(64'd99, "b2b", 0);
    single_pulse("b2b");
    issue(32'd100, 32'd200, 1'b0);
    bus.valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_stall", 64'(bus.stall), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    reset = 1'b0;
    bus.valid = 1'b1; bus.alu_ctl = 5'b00010;
    #1 chk("nonmul_stall", 64'(bus.stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("nonmul_busy", 64'(bus.busy), 64'd0);
    bus.valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      s = 1'($urandom);
      issue(a, b, s);
      wait_done(ref_mul(a, b, s), $sformatf("rand%0d", i), 0);
      single_pulse($sformatf("rand%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
